gshare_updater: RTL and testbench

//  Front/commit-side companion of the gshare PHT: forms PHT read index (fetch PC ^ speculative GHR),

---
 rtl/gshare_pkg.sv | 20 ++
 rtl/gshare_updater_branch_queue.sv | 81 ++++++++
 rtl/gshare_updater.sv | 126 ++++++++++++
 tb/tb_gshare_updater.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_pkg.sv
// Shared types for the gshare predictor update path: 2-bit counter encoding,
// default geometry and the saturating counter update.
package gshare_pkg;

  localparam int I_WIDTH = 7;
  localparam int DEPTH   = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  function automatic ctr_t sat_update(ctr_t s, logic taken);
    if (taken) return (s == ST)  ? ST  : ctr_t'(s + 2'd1);
    else       return (s == SNT) ? SNT : ctr_t'(s - 2'd1);
  endfunction

endpackage

// File: rtl/gshare_updater_branch_queue.sv
// Circular FIFO of in-flight conditional branches: PHT index plus the counter
// state captured one cycle after fetch, written back into the entry by pointer.
module branch_queue
  import gshare_pkg::*;
#(
  parameter int I_WIDTH = gshare_pkg::I_WIDTH,
  parameter int DEPTH   = gshare_pkg::DEPTH,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [I_WIDTH:0] push_idx_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [PW-1:0]    wr_ptr_i,
  input  ctr_t             wr_state_i,
  output logic [I_WIDTH:0] head_idx_o,
  output ctr_t             head_state_o,
  output logic [PW-1:0]    tail_ptr_o,
  output logic             empty_o,
  output logic             full_o
);

  typedef struct packed {
    logic [I_WIDTH:0] idx;
    ctr_t             state;
  } bq_entry_t;

  bq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW:0]       count_q, count_d;

  // NOTE: entry storage has no reset; validity is tracked only by head/tail/count.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_i].state <= wr_state_i;
    if (push_i)  mem_q[tail_q] <= '{idx: push_idx_i, state: SNT};
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_idx_o   = mem_q[head_q].idx;
  assign head_state_o = mem_q[head_q].state;
  assign tail_ptr_o   = tail_q;
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/gshare_updater.sv
// gshare front/commit companion: forms the PHT read index, tracks in-flight
// branches and produces the PHT counter write plus mispredict/history repair.
module gshare_updater
  import gshare_pkg::*;
#(
  parameter int I_WIDTH = gshare_pkg::I_WIDTH,
  parameter int DEPTH   = gshare_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             fetchValid,
  input  logic [I_WIDTH:0] fetchPC,
  output logic [I_WIDTH:0] index,
  input  logic [1:0]       predState,
  output logic             prediction,
  output logic             queueFull,
  input  logic             commitValid,
  input  logic             commitTaken,
  output logic [I_WIDTH:0] previousIndex,
  output logic [1:0]       newState,
  output logic             predictorWrite,
  output logic             mispredict
);

  localparam int PW = $clog2(DEPTH);

  logic [I_WIDTH:0] ghr_spec_q, ghr_spec_d;
  logic [I_WIDTH:0] ghr_commit_q, ghr_commit_d;
  logic [I_WIDTH:0] ghr_fwd;
  logic             cap_pend_q, cap_pend_d;
  logic [PW-1:0]    cap_ptr_q, cap_ptr_d;
  logic [I_WIDTH:0] prev_index_q, prev_index_d;
  ctr_t             new_state_q, new_state_d;
  logic             pred_write_q, pred_write_d;
  logic             mispredict_q, mispredict_d;

  logic [I_WIDTH:0] head_idx;
  ctr_t             head_state;
  logic [PW-1:0]    tail_ptr;
  logic             q_empty, q_full;
  logic             do_commit, mis_now, push;

  // A branch fetched last cycle already counts in the history used this cycle.
  assign ghr_fwd    = cap_pend_q ? {ghr_spec_q[I_WIDTH-1:0], predState[1]} : ghr_spec_q;
  assign index      = fetchPC ^ ghr_fwd;
  assign prediction = cap_pend_q & predState[1];

  assign do_commit = commitValid & ~q_empty;
  assign mis_now   = do_commit & (commitTaken != head_state[1]);
  assign push      = fetchValid & ~q_full & ~mis_now;

  branch_queue #(.I_WIDTH(I_WIDTH), .DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (resetN),
    .push_i       (push),
    .push_idx_i   (index),
    .pop_i        (do_commit),
    .flush_i      (mis_now),
    .wr_en_i      (cap_pend_q),
    .wr_ptr_i     (cap_ptr_q),
    .wr_state_i   (ctr_t'(predState)),
    .head_idx_o   (head_idx),
    .head_state_o (head_state),
    .tail_ptr_o   (tail_ptr),
    .empty_o      (q_empty),
    .full_o       (q_full)
  );

  always_comb begin
    ghr_spec_d   = ghr_spec_q;
    ghr_commit_d = ghr_commit_q;
    cap_pend_d   = push;
    cap_ptr_d    = push ? tail_ptr : cap_ptr_q;
    prev_index_d = prev_index_q;
    new_state_d  = new_state_q;
    pred_write_d = do_commit;
    mispredict_d = mis_now;

    if (cap_pend_q) ghr_spec_d = {ghr_spec_q[I_WIDTH-1:0], predState[1]};

    if (do_commit) begin
      prev_index_d = head_idx;
      new_state_d  = sat_update(head_state, commitTaken);
      ghr_commit_d = {ghr_commit_q[I_WIDTH-1:0], commitTaken};
    end

    // Repair from the committed view, which now includes this branch's outcome.
    if (mis_now) begin
      ghr_spec_d = {ghr_commit_q[I_WIDTH-1:0], commitTaken};
      cap_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ghr_spec_q   <= '0;
      ghr_commit_q <= '0;
      cap_pend_q   <= 1'b0;
      cap_ptr_q    <= '0;
      prev_index_q <= '0;
      new_state_q  <= SNT;
      pred_write_q <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      ghr_spec_q   <= ghr_spec_d;
      ghr_commit_q <= ghr_commit_d;
      cap_pend_q   <= cap_pend_d;
      cap_ptr_q    <= cap_ptr_d;
      prev_index_q <= prev_index_d;
      new_state_q  <= new_state_d;
      pred_write_q <= pred_write_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign queueFull      = q_full;
  assign previousIndex  = prev_index_q;
  assign newState       = new_state_q;
  assign predictorWrite = pred_write_q;
  assign mispredict     = mispredict_q;

  a_no_fetch_when_full: assert property (
    @(posedge clk) disable iff (!resetN) !(fetchValid && q_full)
  ) else $warning("protocol: fetchValid asserted while queueFull, fetch dropped");

endmodule

// File: tb/tb_gshare_updater.sv
// Directed bench for gshare_updater: reset, update, saturation, forwarding,
// queue full/drop, mispredict repair and asynchronous mid-run reset.
module tb_gshare_updater;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       fetchValid = 1'b0;
  logic [7:0] fetchPC = '0;
  logic [7:0] index;
  logic [1:0] predState = '0;
  logic       prediction;
  logic       queueFull;
  logic       commitValid = 1'b0;
  logic       commitTaken = 1'b0;
  logic [7:0] previousIndex;
  logic [1:0] newState;
  logic       predictorWrite;
  logic       mispredict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gshare_updater #(.I_WIDTH(7), .DEPTH(8)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .fetchValid     (fetchValid),
    .fetchPC        (fetchPC),
    .index          (index),
    .predState      (predState),
    .prediction     (prediction),
    .queueFull      (queueFull),
    .commitValid    (commitValid),
    .commitTaken    (commitTaken),
    .previousIndex  (previousIndex),
    .newState       (newState),
    .predictorWrite (predictorWrite),
    .mispredict     (mispredict)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN      = 1'b0;
    fetchValid  = 1'b0;
    fetchPC     = '0;
    predState   = '0;
    commitValid = 1'b0;
    commitTaken = 1'b0;
    #12;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic fetch_one(input logic [7:0] pc, input logic [1:0] st);
    fetchValid = 1'b1;
    fetchPC    = pc;
    tick();
    fetchValid = 1'b0;
    predState  = st;
    tick();
  endtask

  task automatic commit_one(input logic taken);
    commitValid = 1'b1;
    commitTaken = taken;
    tick();
    commitValid = 1'b0;
  endtask

  task automatic test_reset();
    resetN  = 1'b0;
    fetchPC = 8'h5A;
    #3;
    checks++; if (index !== 8'h5A) begin errors++; $display("FAIL reset_index got %h want 5a", index); end
    checks++; if (queueFull !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", queueFull); end
    checks++; if (predictorWrite !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", predictorWrite, mispredict); end
    checks++; if (previousIndex !== 8'h00 || newState !== 2'b00) begin errors++; $display("FAIL reset_write got %h/%b want 00/00", previousIndex, newState); end
    checks++; if (prediction !== 1'b0) begin errors++; $display("FAIL reset_pred got %b want 0", prediction); end
    do_reset();
  endtask

  task automatic test_basic();
    fetchValid = 1'b1;
    fetchPC    = 8'h12;
    #1;
    checks++; if (index !== 8'h12) begin errors++; $display("FAIL basic_index got %h want 12", index); end
    tick();
    fetchValid = 1'b0;
    predState  = 2'b10;
    #1;
    checks++; if (prediction !== 1'b1) begin errors++; $display("FAIL basic_pred got %b want 1", prediction); end
    tick();
    commit_one(1'b1);
    checks++; if (previousIndex !== 8'h12) begin errors++; $display("FAIL basic_previdx got %h want 12", previousIndex); end
    checks++; if (newState !== 2'b11) begin errors++; $display("FAIL basic_newstate got %b want 11", newState); end
    checks++; if (predictorWrite !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL basic_pulses got %b%b want 10", predictorWrite, mispredict); end
    tick();
    checks++; if (predictorWrite !== 1'b0) begin errors++; $display("FAIL basic_write_drop got %b want 0", predictorWrite); end
    fetchPC = 8'h00;
    #1;
    checks++; if (index !== 8'h01) begin errors++; $display("FAIL basic_ghr_index got %h want 01", index); end
  endtask

  task automatic test_saturation();
    do_reset();
    fetch_one(8'h30, 2'b11);
    commit_one(1'b1);
    checks++; if (newState !== 2'b11 || mispredict !== 1'b0) begin errors++; $display("FAIL sat_st got %b/%b want 11/0", newState, mispredict); end
    fetch_one(8'h31, 2'b00);
    commit_one(1'b0);
    checks++; if (newState !== 2'b00 || mispredict !== 1'b0) begin errors++; $display("FAIL sat_snt got %b/%b want 00/0", newState, mispredict); end
    checks++; if (previousIndex !== 8'h30) begin errors++; $display("FAIL sat_previdx got %h want 30", previousIndex); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fetchValid = 1'b1;
    fetchPC    = 8'h00;
    #1;
    checks++; if (index !== 8'h00) begin errors++; $display("FAIL b2b_index0 got %h want 00", index); end
    tick();
    predState = 2'b11;
    #1;
    checks++; if (index !== 8'h01) begin errors++; $display("FAIL b2b_index1 got %h want 01", index); end
    checks++; if (prediction !== 1'b1) begin errors++; $display("FAIL b2b_pred1 got %b want 1", prediction); end
    tick();
    fetchValid = 1'b0;
    predState  = 2'b00;
    #1;
    checks++; if (prediction !== 1'b0) begin errors++; $display("FAIL b2b_pred2 got %b want 0", prediction); end
    tick();
    checks++; if (index !== 8'h02) begin errors++; $display("FAIL b2b_ghr got %h want 02", index); end
    commit_one(1'b1);
    checks++; if (previousIndex !== 8'h00 || newState !== 2'b11) begin errors++; $display("FAIL b2b_commit0 got %h/%b want 00/11", previousIndex, newState); end
    commit_one(1'b0);
    checks++; if (previousIndex !== 8'h01 || newState !== 2'b00) begin errors++; $display("FAIL b2b_commit1 got %h/%b want 01/00", previousIndex, newState); end
    checks++; if (predictorWrite !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL b2b_pulses got %b%b want 10", predictorWrite, mispredict); end
  endtask

  task automatic test_full();
    logic [7:0] exp_idx [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h20, 8'h21};
    do_reset();
    predState = 2'b01;
    for (int i = 0; i < 8; i++) begin
      fetchValid = 1'b1;
      fetchPC    = 8'(i);
      tick();
    end
    checks++; if (queueFull !== 1'b1) begin errors++; $display("FAIL full_set got %b want 1", queueFull); end
    fetchPC = 8'h08;
    tick();
    fetchValid = 1'b0;
    checks++; if (queueFull !== 1'b1) begin errors++; $display("FAIL full_hold got %b want 1", queueFull); end
    commit_one(1'b0);
    checks++; if (previousIndex !== 8'h00 || newState !== 2'b00) begin errors++; $display("FAIL full_commit0 got %h/%b want 00/00", previousIndex, newState); end
    checks++; if (queueFull !== 1'b0) begin errors++; $display("FAIL full_clear got %b want 0", queueFull); end
    fetchValid  = 1'b1;
    fetchPC     = 8'h20;
    commitValid = 1'b1;
    commitTaken = 1'b0;
    tick();
    commitValid = 1'b0;
    checks++; if (previousIndex !== 8'h01 || queueFull !== 1'b0) begin errors++; $display("FAIL full_fetch_commit got %h/%b want 01/0", previousIndex, queueFull); end
    fetchPC = 8'h21;
    tick();
    fetchValid = 1'b0;
    checks++; if (queueFull !== 1'b1) begin errors++; $display("FAIL full_refill got %b want 1", queueFull); end
    tick();
    for (int i = 0; i < 8; i++) begin
      commit_one(1'b0);
      checks++; if (previousIndex !== exp_idx[i]) begin errors++; $display("FAIL full_drain%0d got %h want %h", i, previousIndex, exp_idx[i]); end
    end
    commit_one(1'b0);
    checks++; if (predictorWrite !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL full_empty_commit got %b%b want 00", predictorWrite, mispredict); end
  endtask

  task automatic test_mispredict();
    do_reset();
    fetch_one(8'h01, 2'b11);
    commit_one(1'b1);
    fetch_one(8'h02, 2'b00);
    commit_one(1'b0);
    fetch_one(8'h03, 2'b11);
    commit_one(1'b1);
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL mis_setup got %b want 0", mispredict); end
    fetch_one(8'h04, 2'b10);
    commitValid = 1'b1;
    commitTaken = 1'b0;
    fetchValid  = 1'b1;
    fetchPC     = 8'h40;
    tick();
    commitValid = 1'b0;
    fetchValid  = 1'b0;
    fetchPC     = 8'h00;
    predState   = 2'b11;
    #1;
    checks++; if (previousIndex !== 8'h01 || newState !== 2'b01) begin errors++; $display("FAIL mis_write got %h/%b want 01/01", previousIndex, newState); end
    checks++; if (mispredict !== 1'b1 || predictorWrite !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b%b want 11", mispredict, predictorWrite); end
    checks++; if (prediction !== 1'b0) begin errors++; $display("FAIL mis_cap_clear got %b want 0", prediction); end
    checks++; if (index !== 8'h0A) begin errors++; $display("FAIL mis_repair got %h want 0a", index); end
    commit_one(1'b1);
    checks++; if (predictorWrite !== 1'b0 || mispredict !== 1'b0) begin errors++; $display("FAIL mis_flushed got %b%b want 00", predictorWrite, mispredict); end
    checks++; if (index !== 8'h0A) begin errors++; $display("FAIL mis_ghr_hold got %h want 0a", index); end
  endtask

  task automatic test_reset_mid();
    fetch_one(8'h10, 2'b10);
    commitValid = 1'b1;
    commitTaken = 1'b1;
    tick();
    commitValid = 1'b0;
    checks++; if (predictorWrite !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", predictorWrite); end
    #2;
    resetN = 1'b0;
    #1;
    checks++; if (predictorWrite !== 1'b0 || previousIndex !== 8'h00 || newState !== 2'b00) begin errors++; $display("FAIL mid_clear got %b/%h/%b want 0/00/00", predictorWrite, previousIndex, newState); end
    fetchPC = 8'h33;
    #1;
    checks++; if (index !== 8'h33) begin errors++; $display("FAIL mid_ghr got %h want 33", index); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_full();
    test_mispredict();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
